// File: rtl/elevator_pkg.sv
// Shared types and default constants for the elevator scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam int FLOORS_DEF        = 4;
  localparam int TRAVEL_CYCLES_DEF = 50_000_000;
  localparam int DOOR_CYCLES_DEF   = 100_000_000;

endpackage

// File: rtl/elevator_scheduler_if.sv
// Switch-side / display-side signal bundle of the elevator scheduler.
// master: the request source and display consumer; slave: the scheduler.
interface elevator_scheduler_if #(
  parameter int FLOORS  = 4,
  parameter int FLOOR_W = 2
);
  logic [FLOORS-1:0]  req;
  logic [FLOOR_W-1:0] cur_floor;
  logic               dir_up;
  logic               moving;
  logic               door_open;
  logic [FLOORS-1:0]  pending;

  modport master (
    output req,
    input  cur_floor, dir_up, moving, door_open, pending
  );

  modport slave (
    input  req,
    output cur_floor, dir_up, moving, door_open, pending
  );
endinterface

// File: rtl/elevator_timer.sv
// Up-counter timing floor travel and door dwell. done pulses while the
// count sits at limit-1; the counter wraps to 0 on that edge.
module elevator_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

  assign done = en && (cnt == limit - 1'b1);

  // Count while enabled, wrap at the terminal count, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (done) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/elevator_scheduler.sv
// Collective (SCAN) elevator scheduler: latches floor calls, moves the car
// while calls remain ahead, reverses when only calls behind remain, and
// times travel between floors and door dwell.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS        = FLOORS_DEF,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int DOOR_CYCLES   = DOOR_CYCLES_DEF,
  parameter int CNT_W         = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  elevator_scheduler_if.slave  bus
);

  state_t             state, state_nxt;
  logic [FLOOR_W-1:0] floor_r, floor_nxt, floor_step, ev_floor;
  logic               dir_r, dir_nxt;
  logic [FLOORS-1:0]  pend_r, pend_nxt;
  logic               moving_r, door_r;
  logic [FLOORS-1:0]  up_mask, dn_mask;
  logic               hit, any_up, any_dn, ahead, behind, run_d;
  logic               tmr_clr, tmr_en, tmr_done;
  logic [CNT_W-1:0]   tmr_limit;

  function automatic logic [FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  // Evaluate the decision rule on the registered requests. In MOVE the
  // rule looks at the floor being arrived at, otherwise at the current one.
  always_comb begin
    floor_step = dir_r ? floor_r + 1'b1 : floor_r - 1'b1;
    ev_floor   = (state == MOVE) ? floor_step : floor_r;
    up_mask    = above_mask(ev_floor);
    dn_mask    = below_mask(ev_floor);
    hit        = pend_r[ev_floor];
    any_up     = |(pend_r & up_mask);
    any_dn     = |(pend_r & dn_mask);
    ahead      = dir_r ? any_up : any_dn;
    behind     = dir_r ? any_dn : any_up;
  end

  // Next-state, floor, direction and request-latch logic.
  always_comb begin
    state_nxt = state;
    floor_nxt = floor_r;
    dir_nxt   = dir_r;
    run_d     = 1'b0;
    case (state)
      IDLE: run_d = 1'b1;
      MOVE: begin
        if (tmr_done) begin
          floor_nxt = floor_step;
          run_d     = 1'b1;
        end
      end
      DOOR: if (tmr_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (run_d) begin
      if (hit) begin
        state_nxt = DOOR;
      end else if (ahead) begin
        state_nxt = MOVE;
      end else if (behind) begin
        state_nxt = MOVE;
        dir_nxt   = ~dir_r;
      end else begin
        state_nxt = IDLE;
      end
    end
    // A call at the open floor is dropped even if its switch is still held.
    pend_nxt = pend_r | bus.req;
    if (state_nxt == DOOR || state == DOOR) pend_nxt[floor_nxt] = 1'b0;
  end

  assign tmr_en    = (state != IDLE);
  assign tmr_clr   = (state_nxt != state);
  assign tmr_limit = (state == DOOR) ? CNT_W'(DOOR_CYCLES) : CNT_W'(TRAVEL_CYCLES);

  elevator_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  // State, position, direction, requests and decoded status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      floor_r  <= '0;
      dir_r    <= 1'b1;
      pend_r   <= '0;
      moving_r <= 1'b0;
      door_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      floor_r  <= floor_nxt;
      dir_r    <= dir_nxt;
      pend_r   <= pend_nxt;
      moving_r <= (state_nxt == MOVE);
      door_r   <= (state_nxt == DOOR);
    end
  end

  assign bus.cur_floor = floor_r;
  assign bus.dir_up    = dir_r;
  assign bus.moving    = moving_r;
  assign bus.door_open = door_r;
  assign bus.pending   = pend_r;

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler and car-motion sequencer for the elevator design. It latches floor-call requests from the switch inputs and serves them with a collective (SCAN) policy: it keeps moving in the current direction while requests remain ahead, then reverses. It tracks the car position and times the per-floor travel and door dwell. The display/LED driver consumes its outputs; it sits between the switch inputs and the display/LED logic inside the elevator top level.

## Interface
- `FLOORS`, default 4: number of floors, 2..16.
- `FLOOR_W`, default 2: floor index width, equal to clog2(FLOORS).
- `TRAVEL_CYCLES`, default 50_000_000: cycles spent moving between adjacent floors, ≥2.
- `DOOR_CYCLES`, default 100_000_000: cycles the door stays open, ≥2.
- `CNT_W`, default 27: timer width, wide enough for max(TRAVEL_CYCLES, DOOR_CYCLES).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  FLOORS  call request per floor; a level input, already synchronised (SW).
- `cur_floor`  out  FLOOR_W  current car floor.
- `dir_up`  out  1  current direction: 1 = up, 0 = down.
- `moving`  out  1  high in state MOVE.
- `door_open`  out  1  high in state DOOR.
- `pending`  out  FLOORS  latched, unserved requests (LED).

## Operation
- States: IDLE, MOVE, DOOR.
- Reset values: state IDLE, `cur_floor` 0, `dir_up` 1, `pending` 0, `moving` 0, `door_open` 0, timer 0.
- Request latch: on each edge, `pending[i]` is set to 1 when `req[i]` is high, except for the clear case below.
- Request clear: `pending[cur_floor]` is cleared on every edge where the next state is DOOR, or the state is DOOR. Clear wins over a simultaneous set, so holding a switch at the open floor does not re-latch it.
- Definitions:
  - "ahead" means any pending bit strictly above `cur_floor` when `dir_up` = 1, or strictly below when `dir_up` = 0.
  - "behind" means the same test in the opposite direction.
- Decision rule D, evaluated on the registered `pending` and the arriving or current floor, in priority order:
  1. `pending[floor]` → DOOR.
  2. ahead → MOVE.
  3. behind → toggle `dir_up`, then MOVE.
  4. otherwise → IDLE.
- IDLE: apply D every cycle.
- MOVE:
  - The timer counts 0..TRAVEL_CYCLES-1.
  - At the terminal count, `cur_floor` steps ±1 per `dir_up`, and D is applied to the new floor in the same edge.
  - If the result is MOVE, the timer reloads.
- DOOR:
  - The timer counts 0..DOOR_CYCLES-1.
  - At the terminal count, go to IDLE with the timer cleared.
- The car never leaves the range 0..FLOORS-1. This holds because a move requires a pending floor ahead. The bench asserts it.
- Entering any state resets the timer to 0.

## Timing
- All outputs are registered. `moving` and `door_open` are decoded from the state register.
- From `req[i]` sampled high at edge k: `pending[i]` = 1 after edge k, and the FSM reacts at edge k+1.
- Call at the current floor while IDLE: DOOR is entered at edge k+1, and `pending[i]` stays low or is cleared by edge k+1.
- Call n floors away: MOVE is entered at k+1, and DOOR at k+1+n·TRAVEL_CYCLES.
- DOOR lasts exactly DOOR_CYCLES cycles, and IDLE follows.
- Requests arriving during MOVE for a floor ahead are served on the pass. A floor the car has already left is served after reversal.
- A request for the arriving floor that latches in the same edge as arrival is not seen by D at that edge. The car continues and serves it later.
- `rst_n` asserted mid-move or with the door open: all registers return to reset values immediately (asynchronously), and all pending requests are lost.

## Structure
- Package `elevator_pkg` holds:
  - the state typedef (IDLE/MOVE/DOOR);
  - the default constants for FLOORS, TRAVEL_CYCLES and DOOR_CYCLES.
- One sub-module, `elevator_timer`: a CNT_W up-counter with `clr` and `en` inputs. It compares against a runtime limit and outputs a `done` pulse at limit-1.
- The scheduler muxes the limit by state.
- The "ahead" and "behind" reductions are combinational masks built from `cur_floor`.

## Test plan
All scenarios use the overrides TRAVEL_CYCLES = 4 and DOOR_CYCLES = 3.
1. Reset check: hold `rst_n` low, then release. All outputs read 0, except `dir_up` = 1, and the state stays IDLE with no requests.
2. Single far call: `req` = 4'b0100 pulsed for 1 cycle at floor 0.
   - MOVE at k+1, `cur_floor` = 1 at k+5, `cur_floor` = 2 with `door_open` = 1 at k+9, IDLE at k+12.
   - `pending` = 0 from k+9.
3. Pick-up on the pass: car moving from floor 0 toward 3, with `req[2]` raised while between floors 0 and 1. The car stops at 2 (DOOR), then continues to 3.
4. Reversal: car at floor 3 going up, `pending` = 4'b0001. `dir_up` → 0 at the decision edge, and the car arrives at 0 after 3·TRAVEL_CYCLES.
5. Current-floor clear: hold `req[cur_floor]` high throughout DOOR. `pending[cur_floor]` stays 0, and no second DOOR cycle occurs.
6. Async reset mid-move: assert `rst_n` low while `moving` = 1 at floor 2. All outputs reach reset values without a clock edge, and requests are cleared.
